// File: rtl/ecsu_dwell.sv
// Environmental condition supervision unit with dwell-filtered alert levels,
// latched emergency and a saturating severe-entry counter.
module ecsu_dwell #(
    parameter int WIND_W       = 6,
    parameter int TEMP_W       = 8,
    parameter int WIND_CAUTION = 10,
    parameter int WIND_SEVERE  = 15,
    parameter int WIND_EMERG   = 20,
    parameter int TEMP_SEVERE  = 35,
    parameter int TEMP_EMERG   = 40,
    parameter int UP_DWELL     = 2,
    parameter int DOWN_DWELL   = 4,
    parameter int CNT_W        = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              thunderstorm,
    input  logic [WIND_W-1:0] wind,
    input  logic [1:0]        visibility,
    input  logic [TEMP_W-1:0] temperature,
    input  logic              ack_emergency,
    output logic              severe_weather,
    output logic              emergency_landing_alert,
    output logic [1:0]        ECSU_state,
    output logic [CNT_W-1:0]  severe_event_count
);

    localparam logic [1:0] S_CLEAR = 2'b00;
    localparam logic [1:0] S_CAUT  = 2'b01;
    localparam logic [1:0] S_HIGH  = 2'b10;
    localparam logic [1:0] S_EMERG = 2'b11;

    localparam int MAXD = (UP_DWELL > DOWN_DWELL) ? UP_DWELL : DOWN_DWELL;
    localparam int DW   = (MAXD < 2) ? 1 : $clog2(MAXD + 1);

    localparam logic [DW-1:0] L_UP  = DW'(UP_DWELL);
    localparam logic [DW-1:0] L_DN  = DW'(DOWN_DWELL);
    localparam logic [DW-1:0] L_ONE = DW'(1);

    localparam logic [WIND_W-1:0] L_WC = WIND_W'(WIND_CAUTION);
    localparam logic [WIND_W-1:0] L_WS = WIND_W'(WIND_SEVERE);
    localparam logic [WIND_W-1:0] L_WE = WIND_W'(WIND_EMERG);

    localparam logic signed [TEMP_W-1:0] L_TS  = TEMP_W'(TEMP_SEVERE);
    localparam logic signed [TEMP_W-1:0] L_TSN = TEMP_W'(-TEMP_SEVERE);
    localparam logic signed [TEMP_W-1:0] L_TE  = TEMP_W'(TEMP_EMERG);
    localparam logic signed [TEMP_W-1:0] L_TEN = TEMP_W'(-TEMP_EMERG);

    logic [1:0]        r_state;
    logic [DW-1:0]     r_cnt;
    logic              r_dir;
    logic              r_sev;
    logic              r_alert;
    logic [CNT_W-1:0]  r_events;

    logic signed [TEMP_W-1:0] w_temp;
    logic              w_emerg;
    logic              w_severe;
    logic              w_caution;
    logic [1:0]        w_tgt;
    logic [1:0]        w_nstate;
    logic [DW-1:0]     w_ncnt;
    logic              w_ndir;
    logic [DW-1:0]     w_run;
    logic              w_entry;

    assign w_temp = temperature;

    always_comb begin
        w_emerg   = (wind > L_WE) | (w_temp > L_TE) | (w_temp < L_TEN);
        w_severe  = w_emerg | thunderstorm | (wind > L_WS)
                  | (w_temp > L_TS) | (w_temp < L_TSN)
                  | (visibility == 2'b11);
        w_caution = (wind > L_WC) | (visibility == 2'b01)
                  | (visibility == 2'b10);
        if (w_emerg)        w_tgt = S_EMERG;
        else if (w_severe)  w_tgt = S_HIGH;
        else if (w_caution) w_tgt = S_CAUT;
        else                w_tgt = S_CLEAR;
    end

    // r_dir: 1 = counting up, 0 = counting down; a flip restarts at one
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_ndir   = r_dir;
        w_run    = L_ONE;
        if (r_state == S_EMERG) begin
            w_ncnt = '0;
            if (ack_emergency && (w_tgt != S_EMERG))
                w_nstate = S_HIGH;
        end else if (w_tgt == S_EMERG) begin
            w_nstate = S_EMERG;
            w_ncnt   = '0;
        end else if (w_tgt > r_state) begin
            w_ndir = 1'b1;
            w_run  = (r_dir && (r_cnt != '0)) ? r_cnt + L_ONE : L_ONE;
            if (w_run >= L_UP) begin
                w_nstate = w_tgt;
                w_ncnt   = '0;
            end else begin
                w_ncnt = w_run;
            end
        end else if (w_tgt < r_state) begin
            w_ndir = 1'b0;
            w_run  = (!r_dir && (r_cnt != '0)) ? r_cnt + L_ONE : L_ONE;
            if (w_run >= L_DN) begin
                w_nstate = r_state - 2'd1;
                w_ncnt   = '0;
            end else begin
                w_ncnt = w_run;
            end
        end else begin
            w_ncnt = '0;
        end
        w_entry = !r_state[1] && w_nstate[1];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_CLEAR;
            r_cnt    <= '0;
            r_dir    <= 1'b0;
            r_sev    <= 1'b0;
            r_alert  <= 1'b0;
            r_events <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_dir   <= w_ndir;
            r_sev   <= w_severe;
            r_alert <= (w_nstate == S_EMERG);
            if (w_entry && (r_events != '1))
                r_events <= r_events + 1'b1;
        end
    end

    assign severe_weather          = r_sev;
    assign emergency_landing_alert = r_alert;
    assign ECSU_state              = r_state;
    assign severe_event_count      = r_events;

endmodule

// File: tb/tb_ecsu_dwell.sv
// Scoreboard bench for ecsu_dwell: a reference model pushes expected outputs
// per edge, popped and compared after the edge; a CNT_W=2 copy checks saturation.
module tb_ecsu_dwell;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       thunderstorm = 1'b0;
    logic [5:0] wind = '0;
    logic [1:0] visibility = '0;
    logic [7:0] temperature = '0;
    logic       ack_emergency = 1'b0;

    logic       sev, alert, sev2, alert2;
    logic [1:0] state, state2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int st;
        int sv;
        int ct;
        int ct2;
    } exp_t;

    exp_t sb[$];

    int m_state = 0, m_up = 0, m_dn = 0, m_sev = 0, m_cnt = 0, m_cnt2 = 0;

    always #5 CLK = ~CLK;

    ecsu_dwell u_dut (
        .CLK(CLK), .RST(RST), .thunderstorm(thunderstorm), .wind(wind),
        .visibility(visibility), .temperature(temperature),
        .ack_emergency(ack_emergency), .severe_weather(sev),
        .emergency_landing_alert(alert), .ECSU_state(state),
        .severe_event_count(cnt)
    );

    ecsu_dwell #(.CNT_W(2)) u_sat (
        .CLK(CLK), .RST(RST), .thunderstorm(thunderstorm), .wind(wind),
        .visibility(visibility), .temperature(temperature),
        .ack_emergency(ack_emergency), .severe_weather(sev2),
        .emergency_landing_alert(alert2), .ECSU_state(state2),
        .severe_event_count(cnt2)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, evaluated with the inputs present before the edge
    task automatic model;
        int t, w, tg, prev;
        bit em, sv, ca;
        t  = int'($signed(temperature));
        w  = int'(wind);
        em = (w > 20) || (t > 40) || (t < -40);
        sv = em || thunderstorm || (w > 15) || (t > 35) || (t < -35)
             || (visibility == 2'b11);
        ca = (w > 10) || (visibility == 2'b01) || (visibility == 2'b10);
        tg = em ? 3 : sv ? 2 : ca ? 1 : 0;
        if (RST) begin
            m_state = 0; m_up = 0; m_dn = 0; m_sev = 0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            prev = m_state;
            if (m_state == 3) begin
                m_up = 0; m_dn = 0;
                if (ack_emergency && tg < 3) m_state = 2;
            end else if (tg == 3) begin
                m_state = 3; m_up = 0; m_dn = 0;
            end else if (tg > m_state) begin
                m_dn = 0; m_up++;
                if (m_up >= 2) begin m_state = tg; m_up = 0; end
            end else if (tg < m_state) begin
                m_up = 0; m_dn++;
                if (m_dn >= 4) begin m_state--; m_dn = 0; end
            end else begin
                m_up = 0; m_dn = 0;
            end
            if (prev < 2 && m_state >= 2) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            m_sev = sv;
        end
        sb.push_back('{m_state, m_sev, m_cnt, m_cnt2});
    endtask

    task automatic step(input logic rst, input logic th, input logic [5:0] w,
                        input logic [1:0] v, input logic [7:0] t,
                        input logic ack);
        exp_t e;
        RST = rst; thunderstorm = th; wind = w;
        visibility = v; temperature = t; ack_emergency = ack;
        model();
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("state", int'(state), e.st);
            chk("sev", int'(sev), e.sv);
            chk("alert", int'(alert), int'(e.st == 3));
            chk("cnt", int'(cnt), e.ct);
            chk("state2", int'(state2), e.st);
            chk("cnt2", int'(cnt2), e.ct2);
        end
    endtask

    task automatic clr(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_state", int'(state), 0);
        chk("rst_cnt", int'(cnt), 0);

        step(0, 0, 12, 0, 0, 0);
        step(0, 0, 5, 0, 0, 0);
        chk("caut_hold", int'(state), 0);
        step(0, 0, 12, 0, 0, 0);
        chk("caut_e1", int'(state), 0);
        step(0, 0, 12, 0, 0, 0);
        chk("caut_e2", int'(state), 1);
        clr(4);
        chk("back_clear", int'(state), 0);

        step(0, 1, 0, 0, 0, 0);
        chk("th_sev1", int'(sev), 1);
        chk("th_st1", int'(state), 0);
        step(0, 1, 0, 0, 0, 0);
        chk("th_st2", int'(state), 2);
        chk("th_cnt", int'(cnt), 1);

        step(0, 0, 0, 0, 0, 1);
        chk("ack_noeff", int'(state), 2);

        step(0, 0, 0, 0, 8'hD7, 0);
        chk("em_st", int'(state), 3);
        chk("em_alert", int'(alert), 1);
        chk("em_cnt", int'(cnt), 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 8'd20, 0);
        chk("em_latch", int'(state), 3);
        step(0, 0, 0, 0, 8'hD7, 1);
        chk("ack_t3", int'(state), 3);
        step(0, 0, 0, 0, 8'd20, 1);
        chk("ack_st", int'(state), 2);
        chk("ack_alert", int'(alert), 0);

        clr(3);
        chk("dn_3", int'(state), 2);
        step(0, 0, 0, 2'b11, 0, 0);
        clr(3);
        chk("dn_restart", int'(state), 2);
        clr(1);
        chk("dn_step1", int'(state), 1);
        clr(4);
        chk("dn_step0", int'(state), 0);

        step(0, 0, 15, 0, 0, 0);
        chk("w15", int'(sev), 0);
        step(0, 0, 0, 0, 8'd35, 0);
        chk("t35", int'(sev), 0);
        step(0, 0, 0, 0, 8'hDD, 0);
        chk("tm35", int'(sev), 0);
        step(0, 0, 16, 0, 0, 0);
        chk("w16", int'(sev), 1);
        step(0, 0, 20, 0, 0, 0);
        chk("w20", int'(state == 2'b11), 0);
        step(0, 0, 21, 0, 0, 0);
        chk("w21", int'(state), 3);

        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 12, 0, 0, 0);
        step(0, 0, 12, 0, 0, 0);
        chk("mid_caut", int'(state), 1);
        clr(2);
        step(1, 0, 0, 0, 0, 0);
        chk("mid_rst_st", int'(state), 0);
        chk("mid_rst_sev", int'(sev), 0);

        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 0, 0, 0);
            step(0, 1, 0, 0, 0, 0);
            clr(8);
        end
        chk("sat_cnt2", int'(cnt2), 3);
        chk("sat_cnt", int'(cnt), 5);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 60) == 0),
                 ($urandom_range(0, 7) == 0),
                 6'($urandom_range(0, 24)),
                 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ecsu_dwell.md
Name: ecsu_dwell

Overview:
- Parametrised successor of the environmental condition supervision unit.
- Classifies wind, temperature, visibility and thunderstorm inputs into four alert levels.
- Escalates and de-escalates only after programmable dwell times.
- Emergency is latched until the pilot acknowledges, and severe-weather entries are counted.
- Sits between the sensor-sampling front end and the cockpit alert/annunciator logic.

Parameters:
- WIND_W, 6, wind input width (unsigned)
- TEMP_W, 8, temperature input width (two's complement)
- WIND_CAUTION, 10, wind strictly above this is caution
- WIND_SEVERE, 15, wind strictly above this is severe
- WIND_EMERG, 20, wind strictly above this is emergency
- TEMP_SEVERE, 35, |temperature| strictly above this is severe
- TEMP_EMERG, 40, |temperature| strictly above this is emergency
- UP_DWELL, 2, consecutive edges needed to escalate (>=1)
- DOWN_DWELL, 4, consecutive edges needed to de-escalate one level (>=1)
- CNT_W, 8, width of severe_event_count

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  synchronous, active-high reset
- thunderstorm  in  1  thunderstorm detected
- wind  in  WIND_W  wind speed, unsigned
- visibility  in  2  00 clear, 01 reduced, 10 poor, 11 zero
- temperature  in  TEMP_W  signed temperature
- ack_emergency  in  1  pilot acknowledge of emergency
- severe_weather  out  1  registered severe condition
- emergency_landing_alert  out  1  high while in EMERGENCY
- ECSU_state  out  2  00 ALL_CLEAR, 01 CAUTION, 10 HIGH_ALERT, 11 EMERGENCY
- severe_event_count  out  CNT_W  saturating count of entries into HIGH_ALERT or EMERGENCY

Behaviour:
- Reset
  - Clock and reset are one clock CLK with synchronous, active-high reset RST.
  - When RST is high at a rising edge, all outputs and the dwell counter go to 0 and state goes to ALL_CLEAR.
  - RST has priority over every other event, including mid-dwell and in EMERGENCY.
  - Asserting RST between edges has no effect until the next edge.
- Classification (combinational, current inputs, signed compares on temperature)
  - emerg_c = wind>WIND_EMERG | temperature>TEMP_EMERG | temperature<-TEMP_EMERG
  - severe_c = emerg_c | thunderstorm | wind>WIND_SEVERE | temperature>TEMP_SEVERE | temperature<-TEMP_SEVERE | visibility==11
  - caution_c = wind>WIND_CAUTION | visibility==01 | visibility==10
  - Target level T = 3 if emerg_c, else 2 if severe_c, else 1 if caution_c, else 0.
  - All thresholds are strict: wind==15 and temperature==+/-35 are not severe.
- severe_weather
  - Registered from severe_c every edge, giving 1-cycle latency.
  - Independent of the dwell logic.
- Dwell counter
  - A single counter tracks consecutive edges with T>state (UP) or T<state (DOWN).
  - It clears when T==state, when direction flips, and on every state change.
- Escalation
  - T==3: go to EMERGENCY on the same edge, with no dwell.
  - Otherwise, on the UP_DWELL-th consecutive edge with T>state, state becomes T directly (ALL_CLEAR can jump to HIGH_ALERT).
  - UP_DWELL=1 means the next edge.
- De-escalation
  - Steps one level down on the DOWN_DWELL-th consecutive edge with T<state.
  - EMERGENCY is exempt from dwell: it leaves only on an edge with ack_emergency=1 and T<3, going to HIGH_ALERT and clearing the counter.
  - ack_emergency with T==3 is ignored.
  - ack_emergency outside EMERGENCY has no effect.
- emergency_landing_alert equals (state==EMERGENCY), registered with the state.
- severe_event_count
  - Increments on an edge where state goes from ALL_CLEAR or CAUTION to HIGH_ALERT or EMERGENCY.
  - A HIGH_ALERT to EMERGENCY transition does not count.
  - Saturates at 2^CNT_W-1; cleared only by RST.
- Illegal or unreachable encodings: none; all four encodings are defined states.

Test Plan:
- Caution dwell (defaults): after reset, wind=12 for 1 edge then 5 -> ECSU_state stays 00. Then wind=12 for 2 edges -> ECSU_state=01 on the 2nd edge.
- Direct escalation: from 00, thunderstorm=1 for 2 edges -> severe_weather=1 after edge 1, ECSU_state=10 after edge 2, severe_event_count=1.
- Emergency latch: temperature=8'hD7 (-41) for 1 edge -> ECSU_state=11 and emergency_landing_alert=1 on that edge. Then temperature=20 for 10 edges -> stays 11. Then ack_emergency=1 for 1 edge -> 10, alert=0.
- Stepwise de-escalation: from 10, all inputs clear for 3 edges, then visibility=11 for 1 edge, then clear for 4 edges -> 01 only at the final edge (counter restarted). 4 more clear edges -> 00.
- Boundaries: wind=15, temperature=35, then -35 -> severe_weather=0. wind=16 -> severe_weather=1. wind=20 -> no emergency. wind=21 -> ECSU_state=11 on the same edge.
- Reset and saturation: RST=1 mid-dwell in CAUTION -> all outputs 0 at that edge. With CNT_W=2, five 00->10 entries -> severe_event_count=3.
